// File: rtl/ram_ctrl_pkg.sv
// Shared constants, state type and helpers for the RAM word write path.
// Optional lane parity output: RAM_WORD_WRITER_PARITY_EN.
package ram_ctrl_pkg;

    localparam int WORD_W = 64;
    localparam int LANE_W = 8;
    localparam int ADDR_W = 6;
    localparam int LANES  = WORD_W / LANE_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } wr_state_t;

    function automatic logic [LANES-1:0] lane_parity(
        input logic [WORD_W-1:0] w
    );
        logic [LANES-1:0] p;
        p = '0;
        for (int i = 0; i < LANES; i++) begin
            p[i] = ^w[i*LANE_W +: LANE_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational merge of one byte or bit write into the held word.
// Also produces the one-hot of the lane touched by the write.
module lane_merge
    import ram_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [ADDR_W-1:0] add_i,
    input  logic              mode_i,
    input  logic [LANE_W-1:0] din_byte_i,
    input  logic              din_bit_i,
    output logic [WORD_W-1:0] word_o,
    output logic [LANES-1:0]  lane_oh_o
);

    logic [2:0] lane;

    assign lane = add_i[ADDR_W-1:3];

    always_comb begin
        word_o    = word_i;
        lane_oh_o = '0;
        lane_oh_o[lane] = 1'b1;
        unique case (1'b1)
            mode_i:  word_o[lane*LANE_W +: LANE_W] = din_byte_i;
            !mode_i: word_o[add_i] = din_bit_i;
            default: word_o = word_i;
        endcase
    end

endmodule

// File: rtl/ram_word_writer.sv
// Merges byte/bit writes into a 64-bit word and flushes it downstream.
// Optional lane parity output: RAM_WORD_WRITER_PARITY_EN.
module ram_word_writer
    import ram_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] add,
    input  logic              mode,
    input  logic [LANE_W-1:0] din_byte,
    input  logic              din_bit,
    input  logic              req,
    input  logic              commit,
    input  logic              data_ready,
`ifdef RAM_WORD_WRITER_PARITY_EN
    output logic [LANES-1:0]  parity,
`endif
    output logic              ack,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic [LANES-1:0]  dirty,
    output logic              busy
);

    wr_state_t         state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic [LANES-1:0]  dirty_q, dirty_d;
    logic              ack_q, ack_d;

    logic [WORD_W-1:0] merged;
    logic [LANES-1:0]  lane_oh;
    logic              accept;
    logic [LANES-1:0]  dirty_upd;
    logic [WORD_W-1:0] word_upd;

    lane_merge u_merge (
        .word_i     (word_q),
        .add_i      (add),
        .mode_i     (mode),
        .din_byte_i (din_byte),
        .din_bit_i  (din_bit),
        .word_o     (merged),
        .lane_oh_o  (lane_oh)
    );

    assign accept    = (state_q == IDLE) && req;
    assign dirty_upd = dirty_q | (accept ? lane_oh : '0);
    assign word_upd  = accept ? merged : word_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_upd;
        dirty_d = dirty_upd;
        dout_d  = dout_q;
        ack_d   = accept;
        unique case (state_q)
            IDLE: begin
                // A same-edge write counts toward both commit and auto-flush.
                if ((commit && (dirty_upd != '0)) || (&dirty_upd)) begin
                    state_d = FLUSH;
                    dout_d  = word_upd;
                end
            end
            FLUSH: begin
                if (data_ready) begin
                    state_d = IDLE;
                    dirty_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            word_q  <= RESET_WORD;
            dout_q  <= RESET_WORD;
            dirty_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dout_q  <= dout_d;
            dirty_q <= dirty_d;
            ack_q   <= ack_d;
        end
    end

`ifdef RAM_WORD_WRITER_PARITY_EN
    logic [LANES-1:0] par_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= lane_parity(RESET_WORD);
        end else begin
            par_q <= lane_parity(dout_d);
        end
    end

    assign parity = par_q;
`endif

    assign ack        = ack_q;
    assign data_out   = dout_q;
    assign data_valid = (state_q == FLUSH);
    assign busy       = (state_q != IDLE);
    assign dirty      = dirty_q;

endmodule

// File: doc/ram_word_writer.md
# ram_word_writer

Write-side counterpart of the byte/bit read path. Accepts byte or single-bit write requests addressed with the same 6-bit byte/bit address map the read path uses, merges them into a held 64-bit word, and hands the completed word downstream over a valid/ready handshake. It sits ahead of the 64-bit shift-register load, which it drives with `data_out`/`data_valid`.

## Interface
- `RESET_WORD`, 64'h0: word contents after reset.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `add` input 6: `add[5:3]` selects the byte lane, `add[2:0]` selects the bit within the lane; absolute bit = 8*add[5:3]+add[2:0].
- `mode` input 1: 1 = byte write (`din_byte` to lane), 0 = bit write (`din_bit` to the addressed bit).
- `din_byte` input 8: byte write data.
- `din_bit` input 1: bit write data.
- `req` input 1: write request; held until acknowledged.
- `commit` input 1: flush request.
- `ack` output 1: one-cycle pulse, write accepted.
- `data_out` output 64: flushed word; lane b = `data_out[8b+7:8b]`.
- `data_valid` output 1: `data_out` is valid for the downstream load.
- `data_ready` input 1: downstream accepts `data_out`.
- `dirty` output 8: lanes written since the last flush.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- States: IDLE, FLUSH.
- IDLE, `req`=1 at an edge: merge into the word and set `dirty[add[5:3]]`. Byte write replaces the lane. Bit write changes only the addressed bit. `ack`=1 for the next cycle. Back-to-back requests are accepted every cycle.
- IDLE to FLUSH at an edge where either condition holds:
  - `commit`=1 and (`dirty`!=0 or a write is accepted on the same edge).
  - The updated `dirty` equals 8'hFF (auto-flush).
- On entry to FLUSH, `data_out` loads the updated word, so a same-edge write is included.
- `commit` with `dirty`==0 and no write is ignored; there is no empty flush.
- FLUSH:
  - `data_valid`=1 and `data_out` stays stable.
  - `req` is not accepted and `ack` stays 0; the requester holds `req`.
  - `commit` is ignored.
- FLUSH to IDLE at an edge with `data_ready`=1: `dirty` clears to 0. Word contents are retained, so unwritten bits carry into the next word.
- Writing the same lane repeatedly: last write wins; `dirty` is unchanged.
- Reset values: `ack`=0, `data_valid`=0, `busy`=0, `dirty`=0, `data_out`=`RESET_WORD`, internal word=`RESET_WORD`, state IDLE.

## Timing
- Write latency: `req` sampled at edge N, `ack` high during N to N+1, merged word visible to a flush from edge N.
- Flush: `data_valid` rises the cycle after the triggering edge. Minimum FLUSH duration is 1 cycle when `data_ready` is already high.
- The earliest next write after flush completion is accepted at the edge following the `data_ready` handshake edge.
- `rst` low at any time, including mid-FLUSH: all outputs take their reset values immediately (asynchronously), and any pending write is dropped.
- All outputs are registered; none depend combinationally on inputs.

## Configuration
- `RAM_WORD_WRITER_PARITY_EN` defined:
  - Adds output `parity` [7:0], the even parity of each lane of `data_out`.
  - Registered together with `data_out`; reset value is the parity of `RESET_WORD`.
- Undefined: the `parity` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `ram_ctrl_pkg`:
  - Constants `WORD_W`=64, `LANE_W`=8, `ADDR_W`=6.
  - State enum `wr_state_t` {IDLE, FLUSH}.
- One sub-module `lane_merge`: combinational merge of word, `add`, `mode`, `din_byte`, `din_bit` into the next word and the lane-select one-hot. The top level holds the FSM, registers and handshake.

## Test plan
- Reset with `RESET_WORD`=64'h0, `rst` low then high: `data_out`=0, `dirty`=0, `ack`/`data_valid`/`busy`=0. Assert `rst` low mid-cycle: outputs clear without a clock edge.
- Byte write `add`=6'd8, `mode`=1, `din_byte`=8'hA5, then `commit`, `data_ready`=1: `ack` pulse; `data_out`=64'h0000_0000_0000_A500; `data_valid` high 1 cycle; `dirty`=8'h02, then 0.
- Bit write `add`=6'd63, `din_bit`=1 after the previous flush, then `commit`: `data_out`=64'h8000_0000_0000_A500 (prior bits retained); `dirty`=8'h80.
- Byte writes to lanes 0..7 with 8'h11..8'h88, no `commit`: after the 8th `ack`, `data_valid`=1, `data_out`=64'h8877_6655_4433_2211, `busy`=1.
- Backpressure: hold `data_ready`=0 for 5 cycles while `req` is held:
  - `ack` stays 0 and `data_out` is stable.
  - Raise `data_ready`: IDLE next cycle, and the held write is acked one cycle later.
- `commit` with `dirty`=0 and no `req`: no `data_valid`. Simultaneous `req`+`commit`: the flushed word includes that write.
